// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze pipeline front end.
package dehaze_pkg;

  localparam int unsigned PIX_W      = 24;
  localparam int unsigned IMG_W_DEF  = 512;
  localparam int unsigned IMG_H_DEF  = 512;
  localparam int unsigned WIN_CENTER = 4;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [8:0]     window_t;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;

  // Flat index of window element (dy, dx).
  function automatic int unsigned win_idx(input int unsigned dy, input int unsigned dx);
    return 3 * dy + dx;
  endfunction

  // Border source select: an off-image outer row/column takes the middle one.
  function automatic logic [1:0] border_src(input logic [1:0] i, input logic lo, input logic hi);
    if (i == 2'd0 && lo) return 2'd1;
    if (i == 2'd2 && hi) return 2'd1;
    return i;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: one read and one write per enabled cycle, read-before-write.
module line_buffer #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned    AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Old contents at ptr were written exactly DEPTH enabled cycles ago.
  assign rd_data = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Raster-stream 3x3 window generator with border handling and end-of-frame flush.
// Define WINDOW_ZERO_PAD_EN to drive off-image elements to 0 instead of replicating.
module window3x3_gen #(
  parameter int unsigned IMG_W = dehaze_pkg::IMG_W_DEF,
  parameter int unsigned IMG_H = dehaze_pkg::IMG_H_DEF,
  parameter int unsigned PIX_W = dehaze_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   input_pixel,
  input  logic               input_is_valid,
  output logic [9*PIX_W-1:0] win_out,
  output logic [31:0]        win_center_xy,
  output logic               output_is_valid,
  output logic               busy,
  output logic               overrun
);

  import dehaze_pkg::*;

  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  state_e      state;
  logic [15:0] in_row, in_col;
  logic [15:0] out_row, out_col;

  logic             accept, advance;
  logic [PIX_W-1:0] lb_in, lb1_rd, lb2_rd;
  logic [PIX_W-1:0] col0 [3];
  logic [PIX_W-1:0] col1 [3];
  logic [PIX_W-1:0] col2 [3];
  logic [PIX_W-1:0] cols [3][3];
  logic [9*PIX_W-1:0] win_next;
  logic first_row, last_row, first_col, last_col;

  // Flush cycles advance the delay lines with a don't-care bottom pixel.
  assign accept  = input_is_valid && (state != FLUSH);
  assign advance = accept || (state == FLUSH);
  assign lb_in   = (state == FLUSH) ? '0 : input_pixel;

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W)
  ) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .wr_data(lb_in),
    .rd_data(lb1_rd)
  );

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W)
  ) u_lb2 (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .wr_data(lb1_rd),
    .rd_data(lb2_rd)
  );

  assign col2[0] = lb2_rd;
  assign col2[1] = lb1_rd;
  assign col2[2] = lb_in;

  assign first_row = (out_row == 16'd0);
  assign last_row  = (out_row == LAST_ROW);
  assign first_col = (out_col == 16'd0);
  assign last_col  = (out_col == LAST_COL);

  always_comb begin
    win_next = '0;
    for (int dy = 0; dy < 3; dy++) begin
      cols[0][dy] = col0[dy];
      cols[1][dy] = col1[dy];
      cols[2][dy] = col2[dy];
    end
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
`ifdef WINDOW_ZERO_PAD_EN
        if (border_src(2'(dy), first_row, last_row) != 2'(dy) ||
            border_src(2'(dx), first_col, last_col) != 2'(dx)) begin
          win_next[win_idx(dy, dx)*PIX_W +: PIX_W] = '0;
        end else begin
          win_next[win_idx(dy, dx)*PIX_W +: PIX_W] = cols[dx][dy];
        end
`else
        win_next[win_idx(dy, dx)*PIX_W +: PIX_W] =
            cols[border_src(2'(dx), first_col, last_col)]
                [border_src(2'(dy), first_row, last_row)];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FILL;
      in_row          <= '0;
      in_col          <= '0;
      out_row         <= '0;
      out_col         <= '0;
      win_out         <= '0;
      win_center_xy   <= '0;
      output_is_valid <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      output_is_valid <= 1'b0;
      busy            <= 1'b0;
      if (state == FLUSH && input_is_valid) begin
        overrun <= 1'b1;
      end
      if (advance) begin
        col0 <= col1;
        col1 <= col2;
        if (accept) begin
          in_col <= (in_col == LAST_COL) ? 16'd0 : in_col + 16'd1;
          if (in_col == LAST_COL) begin
            in_row <= (in_row == LAST_ROW) ? 16'd0 : in_row + 16'd1;
          end
        end
        if (state != FILL) begin
          win_out         <= win_next;
          win_center_xy   <= {out_row, out_col};
          output_is_valid <= 1'b1;
          busy            <= (state == FLUSH);
          out_col         <= last_col ? 16'd0 : out_col + 16'd1;
          if (last_col) begin
            out_row <= last_row ? 16'd0 : out_row + 16'd1;
          end
        end
        unique case (state)
          // Pixel W is the last one that produces no window.
          FILL:  if (in_row == 16'd1 && in_col == 16'd0) state <= RUN;
          RUN:   if (in_row == LAST_ROW && in_col == LAST_COL) state <= FLUSH;
          FLUSH: if (last_row && last_col) state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Randomized self-checking bench for window3x3_gen on a 4x4 frame.
module tb_window3x3_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 24;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            rst;
  logic [PW-1:0]   input_pixel;
  logic            input_is_valid;
  logic [9*PW-1:0] win_out;
  logic [31:0]     win_center_xy;
  logic            output_is_valid;
  logic            busy;
  logic            overrun;

  int n_checks = 0;
  int n_errors = 0;
  int exp_idx;
  bit ov_exp;
  bit directed;
  logic [PW-1:0] frame [N];
  int d00 [9];
  int d33 [9];

  window3x3_gen #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .input_pixel    (input_pixel),
    .input_is_valid (input_is_valid),
    .win_out        (win_out),
    .win_center_xy  (win_center_xy),
    .output_is_valid(output_is_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Neighbourhood of (r,c) straight from the frame, handling off-image positions.
  function automatic logic [9*PW-1:0] model_win(input int r, input int c);
    logic [9*PW-1:0] w;
    int rr, cc;
    bit off;
    w = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        rr  = r + dy - 1;
        cc  = c + dx - 1;
        off = (rr < 0) || (rr >= H) || (cc < 0) || (cc >= W);
        if (rr < 0) rr = 0;
        if (rr >= H) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc >= W) cc = W - 1;
`ifdef WINDOW_ZERO_PAD_EN
        w[(3*dy+dx)*PW +: PW] = off ? '0 : frame[rr*W+cc];
`else
        w[(3*dy+dx)*PW +: PW] = frame[rr*W+cc];
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [9*PW-1:0] pack9(input int e [9]);
    logic [9*PW-1:0] w;
    for (int p = 0; p < 9; p++) w[p*PW +: PW] = PW'(e[p]);
    return w;
  endfunction

  task automatic drive_cycle(input bit v, input logic [PW-1:0] p, input bit exp_v,
                             input bit exp_busy);
    input_pixel    = p;
    input_is_valid = v;
    @(posedge clk);
    #1;
    check_eq("valid", output_is_valid, exp_v);
    check_eq("busy", busy, exp_busy);
    check_eq("overrun", overrun, ov_exp);
    if (output_is_valid && exp_v) begin
      check_eq("center_xy", win_center_xy, {16'(exp_idx / W), 16'(exp_idx % W)});
      check_eq("window", win_out, model_win(exp_idx / W, exp_idx % W));
      if (directed && exp_idx == 0) check_eq("win_0_0", win_out, pack9(d00));
      if (directed && exp_idx == N - 1) check_eq("win_3_3", win_out, pack9(d33));
      exp_idx++;
    end
  endtask

  // mode 0: pixel = k, otherwise random. abort_at >= 0 stops after that many accepts.
  task automatic run_frame(input int mode, input bit gaps, input bit poke, input int abort_at);
    int j;
    bit v;
    for (int k = 0; k < N; k++) frame[k] = (mode == 0) ? PW'(k) : PW'($urandom);
    exp_idx = 0;
    j = 0;
    while (j < N) begin
      if (abort_at >= 0 && j == abort_at) return;
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      drive_cycle(v, v ? frame[j] : PW'($urandom), v && (j >= W + 1), 1'b0);
      if (v) j++;
    end
    for (int i = 0; i <= W; i++) begin
      v = poke && (i == 1 || i == 3);
      if (v) ov_exp = 1'b1;
      drive_cycle(v, PW'($urandom), 1'b1, 1'b1);
    end
    check_eq("win_count", exp_idx, N);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    input_is_valid = 1'b0;
    input_pixel    = '0;
    @(posedge clk);
    #1;
    ov_exp = 1'b0;
    check_eq("rst_valid", output_is_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_win", win_out, '0);
    check_eq("rst_xy", win_center_xy, '0);
    rst = 1'b0;
  endtask

  initial begin
`ifdef WINDOW_ZERO_PAD_EN
    d00 = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
    d33 = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
`else
    d00 = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    d33 = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
`endif
    ov_exp   = 1'b0;
    directed = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    do_reset();

    directed = 1'b1;
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(0, 1'b1, 1'b0, -1);
    directed = 1'b0;
    run_frame(1, 1'b1, 1'b1, -1);
    run_frame(1, 1'b0, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, 8);
    do_reset();
    directed = 1'b1;
    run_frame(0, 1'b0, 1'b0, -1);
    directed = 1'b0;
    for (int f = 0; f < 3; f++) run_frame(1, 1'b1, (f == 1), -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
